// File: rtl/merlin_alu_md_pkg.sv
// Shared opcode space and decode helpers for the merlin ALU / mul-div unit.
package merlin_alu_md_pkg;

  // Opcode field width (RV_ALUOP_RANGE is [4:0]).
  localparam int unsigned RV_ALUOP_W = 5;

  // Single-cycle integer ALU operations.
  localparam logic [4:0] RV_ALUOP_ADD    = 5'd0;
  localparam logic [4:0] RV_ALUOP_SUB    = 5'd1;
  localparam logic [4:0] RV_ALUOP_SLL    = 5'd2;
  localparam logic [4:0] RV_ALUOP_SLT    = 5'd3;
  localparam logic [4:0] RV_ALUOP_SLTU   = 5'd4;
  localparam logic [4:0] RV_ALUOP_XOR    = 5'd5;
  localparam logic [4:0] RV_ALUOP_SRL    = 5'd6;
  localparam logic [4:0] RV_ALUOP_SRA    = 5'd7;
  localparam logic [4:0] RV_ALUOP_OR     = 5'd8;
  localparam logic [4:0] RV_ALUOP_AND    = 5'd9;
  localparam logic [4:0] RV_ALUOP_MOV    = 5'd10;

  // M-extension operations (iterative).
  localparam logic [4:0] RV_ALUOP_MUL    = 5'd16;
  localparam logic [4:0] RV_ALUOP_MULH   = 5'd17;
  localparam logic [4:0] RV_ALUOP_MULHSU = 5'd18;
  localparam logic [4:0] RV_ALUOP_MULHU  = 5'd19;
  localparam logic [4:0] RV_ALUOP_DIV    = 5'd20;
  localparam logic [4:0] RV_ALUOP_DIVU   = 5'd21;
  localparam logic [4:0] RV_ALUOP_REM    = 5'd22;
  localparam logic [4:0] RV_ALUOP_REMU   = 5'd23;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= RV_ALUOP_MUL) && (op <= RV_ALUOP_REMU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return op inside {RV_ALUOP_DIV, RV_ALUOP_DIVU, RV_ALUOP_REM, RV_ALUOP_REMU};
  endfunction

  function automatic logic is_rem_op(input logic [4:0] op);
    return op inside {RV_ALUOP_REM, RV_ALUOP_REMU};
  endfunction

  // rs1 is treated as signed.
  function automatic logic is_signed_l(input logic [4:0] op);
    return op inside {RV_ALUOP_MULH, RV_ALUOP_MULHSU, RV_ALUOP_DIV, RV_ALUOP_REM};
  endfunction

  // rs2 is treated as signed.
  function automatic logic is_signed_r(input logic [4:0] op);
    return op inside {RV_ALUOP_MULH, RV_ALUOP_DIV, RV_ALUOP_REM};
  endfunction

endpackage

// File: rtl/merlin_muldiv_iter.sv
// Iterative radix-2 datapath: shift-add multiply and restoring divide on magnitudes.
// acc_o holds the unsigned product, or {remainder, quotient}, once done_o has fired.
module merlin_muldiv_iter
  import merlin_alu_md_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk_i,
  input  logic              resetb_i,
  input  logic              clk_en_i,
  input  logic              flush_i,
  input  logic              start_i,
  input  logic [4:0]        op_i,
  input  logic [XLEN-1:0]   left_i,
  input  logic [XLEN-1:0]   right_i,
  output logic              done_o,
  output logic [2*XLEN-1:0] acc_o,
  output logic              neg_res_o,
  output logic              neg_rem_o
);

  localparam int unsigned CW = $clog2(XLEN);

  logic              r_busy;
  logic              r_div;
  logic              r_neg_res;
  logic              r_neg_rem;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_opnd;  // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] r_acc;   // low half starts as multiplier / dividend

  logic              w_sign_l;
  logic              w_sign_r;
  logic [XLEN-1:0]   w_mag_l;
  logic [XLEN-1:0]   w_mag_r;
  logic [XLEN:0]     w_msum;
  logic [XLEN:0]     w_dtrial;
  logic              w_dok;
  logic [2*XLEN-1:0] w_mul_next;
  logic [2*XLEN-1:0] w_div_next;

  // Operand magnitudes and one radix-2 step of each algorithm.
  always_comb begin
    w_sign_l   = is_signed_l(op_i) & left_i[XLEN-1];
    w_sign_r   = is_signed_r(op_i) & right_i[XLEN-1];
    w_mag_l    = w_sign_l ? (~left_i + 1'b1) : left_i;
    w_mag_r    = w_sign_r ? (~right_i + 1'b1) : right_i;
    // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift.
    w_msum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opnd};
    w_mul_next = r_acc[0] ? {w_msum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};
    // Divide: shift in the next dividend bit and subtract the divisor if it fits.
    w_dtrial   = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opnd};
    w_dok      = ~w_dtrial[XLEN];
    w_div_next = {(w_dok ? w_dtrial[XLEN-1:0] : r_acc[2*XLEN-2:XLEN-1]),
                  r_acc[XLEN-2:0], w_dok};
  end

  // Load on start, then one step per enabled edge until the counter expires.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_busy    <= 1'b0;
      r_div     <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_cnt     <= '0;
      r_opnd    <= '0;
      r_acc     <= '0;
    end else if (clk_en_i) begin
      if (flush_i) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else if (start_i) begin
        r_busy    <= 1'b1;
        r_div     <= is_div_op(op_i);
        r_neg_res <= w_sign_l ^ w_sign_r;
        r_neg_rem <= w_sign_l;
        r_cnt     <= CW'(XLEN - 1);
        r_opnd    <= w_mag_r;
        r_acc     <= {{XLEN{1'b0}}, w_mag_l};
      end else if (r_busy) begin
        r_acc <= r_div ? w_div_next : w_mul_next;
        if (r_cnt == '0) begin
          r_busy <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign done_o    = r_busy & (r_cnt == '0);
  assign acc_o     = r_acc;
  assign neg_res_o = r_neg_res;
  assign neg_rem_o = r_neg_rem;

endmodule

// File: rtl/merlin_alu_md.sv
// Execute-stage unit: single-cycle RV ALU plus iterative M-extension mul/div,
// behind a valid/ready request port and a held valid/ready response port.
module merlin_alu_md
  import merlin_alu_md_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            resetb_i,
  input  logic            clk_en_i,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [4:0]      op_opcode_i,
  input  logic [XLEN-1:0] op_left_i,
  input  logic [XLEN-1:0] op_right_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_result_o
);

  localparam int unsigned SW = $clog2(XLEN);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  logic [1:0]        r_state;
  logic [4:0]        r_op;
  logic              r_rsp_valid;
  logic [XLEN-1:0]   r_result;

  logic [SW-1:0]     w_shamt;
  logic              w_md;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_fast;
  logic              w_accept;
  logic              w_start;
  logic              w_load_sc;
  logic [XLEN-1:0]   w_sc_result;
  logic              w_done;
  logic [2*XLEN-1:0] w_acc;
  logic              w_neg_res;
  logic              w_neg_rem;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_result;

  assign req_ready_o = (r_state == ST_IDLE) & ~(r_rsp_valid & ~rsp_ready_i);

  // Request decode: divide special cases bypass the iterative path.
  always_comb begin
    w_shamt    = op_right_i[SW-1:0];
    w_md       = is_muldiv(op_opcode_i);
    w_div_zero = is_div_op(op_opcode_i) & (op_right_i == '0);
    w_div_ovf  = ((op_opcode_i == RV_ALUOP_DIV) | (op_opcode_i == RV_ALUOP_REM)) &
                 (op_left_i == {1'b1, {(XLEN-1){1'b0}}}) & (op_right_i == '1);
    w_fast     = w_div_zero | w_div_ovf;
    w_accept   = clk_en_i & req_valid_i & req_ready_o & ~flush_i;
    w_start    = w_accept & w_md & ~w_fast;
    w_load_sc  = w_accept & ~(w_md & ~w_fast);
  end

  // Single-cycle result, including the divide fast paths.
  always_comb begin
    w_sc_result = '0;
    case (op_opcode_i)
      RV_ALUOP_ADD:  w_sc_result = op_left_i + op_right_i;
      RV_ALUOP_SUB:  w_sc_result = op_left_i - op_right_i;
      RV_ALUOP_SLL:  w_sc_result = op_left_i << w_shamt;
      RV_ALUOP_SLT:  w_sc_result = {{(XLEN-1){1'b0}}, ($signed(op_left_i) < $signed(op_right_i))};
      RV_ALUOP_SLTU: w_sc_result = {{(XLEN-1){1'b0}}, (op_left_i < op_right_i)};
      RV_ALUOP_XOR:  w_sc_result = op_left_i ^ op_right_i;
      RV_ALUOP_SRL:  w_sc_result = op_left_i >> w_shamt;
      RV_ALUOP_SRA:  w_sc_result = $signed(op_left_i) >>> w_shamt;
      RV_ALUOP_OR:   w_sc_result = op_left_i | op_right_i;
      RV_ALUOP_AND:  w_sc_result = op_left_i & op_right_i;
      RV_ALUOP_MOV:  w_sc_result = op_right_i;
      RV_ALUOP_DIV, RV_ALUOP_DIVU: w_sc_result = w_div_zero ? '1 : op_left_i;
      RV_ALUOP_REM, RV_ALUOP_REMU: w_sc_result = w_div_zero ? op_left_i : '0;
      default:       w_sc_result = '0;
    endcase
  end

  merlin_muldiv_iter #(
    .XLEN (XLEN)
  ) u_iter (
    .clk_i     (clk_i),
    .resetb_i  (resetb_i),
    .clk_en_i  (clk_en_i),
    .flush_i   (flush_i),
    .start_i   (w_start),
    .op_i      (op_opcode_i),
    .left_i    (op_left_i),
    .right_i   (op_right_i),
    .done_o    (w_done),
    .acc_o     (w_acc),
    .neg_res_o (w_neg_res),
    .neg_rem_o (w_neg_rem)
  );

  // Sign correction and half selection applied in FIX.
  always_comb begin
    w_prod       = w_neg_res ? (~w_acc + 1'b1) : w_acc;
    w_quot       = w_neg_res ? (~w_acc[XLEN-1:0] + 1'b1) : w_acc[XLEN-1:0];
    w_rem        = w_neg_rem ? (~w_acc[2*XLEN-1:XLEN] + 1'b1) : w_acc[2*XLEN-1:XLEN];
    w_fix_result = '0;
    case (r_op)
      RV_ALUOP_MUL:                                     w_fix_result = w_prod[XLEN-1:0];
      RV_ALUOP_MULH, RV_ALUOP_MULHSU, RV_ALUOP_MULHU:   w_fix_result = w_prod[2*XLEN-1:XLEN];
      RV_ALUOP_DIV, RV_ALUOP_DIVU:                      w_fix_result = w_quot;
      RV_ALUOP_REM, RV_ALUOP_REMU:                      w_fix_result = w_rem;
      default:                                          w_fix_result = '0;
    endcase
  end

  // Control FSM: IDLE -> ITER -> FIX -> IDLE for iterative ops.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
    end else if (clk_en_i) begin
      if (flush_i) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start) begin
              r_state <= ST_ITER;
              r_op    <= op_opcode_i;
            end
          end
          ST_ITER: if (w_done) r_state <= ST_FIX;
          ST_FIX:  r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Response register: held until consumed; a same-edge load wins over the consume.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_rsp_valid <= 1'b0;
      r_result    <= '0;
    end else if (clk_en_i) begin
      if (flush_i) begin
        r_rsp_valid <= 1'b0;
      end else if (w_load_sc) begin
        r_rsp_valid <= 1'b1;
        r_result    <= w_sc_result;
      end else if (r_state == ST_FIX) begin
        r_rsp_valid <= 1'b1;
        r_result    <= w_fix_result;
      end else if (rsp_ready_i) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_result_o = r_result;

endmodule

// File: tb/tb_merlin_alu_md.sv
// Directed vector table plus hand-written multi-cycle sequences for merlin_alu_md.
module tb_merlin_alu_md;
  import merlin_alu_md_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetb, clk_en, flush, req_valid, rsp_ready;
  logic [4:0]  opcode;
  logic [31:0] left, right;
  logic        req_ready, rsp_valid;
  logic [31:0] result;

  logic        req_valid64, req_ready64, rsp_valid64, clk_en64, flush64, rsp_ready64;
  logic [4:0]  opcode64;
  logic [63:0] left64, right64, result64;

  int checks = 0;
  int failures = 0;

  merlin_alu_md #(.XLEN(32)) dut (
    .clk_i(clk), .resetb_i(resetb), .clk_en_i(clk_en), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .op_opcode_i(opcode),
    .op_left_i(left), .op_right_i(right), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_result_o(result)
  );

  merlin_alu_md #(.XLEN(64)) dut64 (
    .clk_i(clk), .resetb_i(resetb), .clk_en_i(clk_en64), .flush_i(flush64),
    .req_valid_i(req_valid64), .req_ready_o(req_ready64), .op_opcode_i(opcode64),
    .op_left_i(left64), .op_right_i(right64), .rsp_valid_o(rsp_valid64),
    .rsp_ready_i(rsp_ready64), .rsp_result_o(result64)
  );

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input string n, input logic [4:0] op, input logic [31:0] l,
                              input logic [31:0] r, input logic [31:0] e, input int lat);
    vec_t v;
    v.name = n; v.op = op; v.l = l; v.r = r; v.exp = e; v.lat = lat;
    vecs.push_back(v);
  endfunction

  // Independent reference using native wide arithmetic.
  function automatic logic [31:0] ref_op(input logic [4:0] op, input logic [31:0] l,
                                         input logic [31:0] r);
    logic signed [63:0] sl, sr;
    logic [63:0]        ul, ur, p;
    sl = {{32{l[31]}}, l};
    sr = {{32{r[31]}}, r};
    ul = {32'd0, l};
    ur = {32'd0, r};
    p  = '0;
    case (op)
      RV_ALUOP_ADD:   p = ul + ur;
      RV_ALUOP_XOR:   p = ul ^ ur;
      RV_ALUOP_SLTU:  p = {63'd0, (l < r)};
      RV_ALUOP_MUL:   p = ul * ur;
      RV_ALUOP_MULHU: p = (ul * ur) >> 32;
      RV_ALUOP_MULH:  p = (sl * sr) >>> 32;
      RV_ALUOP_DIVU:  p = ul / ur;
      RV_ALUOP_REMU:  p = ul % ur;
      RV_ALUOP_DIV:   p = sl / sr;
      RV_ALUOP_REM:   p = sl % sr;
      default:        p = '0;
    endcase
    return p[31:0];
  endfunction

  // Issue one op at a negedge, wait for the response, hold it, then consume it.
  task automatic do_op(input string name, input logic [4:0] op, input logic [31:0] l,
                       input logic [31:0] r, input logic [31:0] exp, input int exp_lat,
                       input int nhold, input bit rnd);
    int d;
    bit busy_bad;
    bit hold_bad;
    opcode = op; left = l; right = r; req_valid = 1'b1;
    check($sformatf("%s ready_at_req", name), req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    d = 0;
    busy_bad = 1'b0;
    while (!rsp_valid && d < 300) begin
      if (req_ready) busy_bad = 1'b1;
      if (rnd) clk_en = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      d++;
      @(negedge clk);
    end
    clk_en = 1'b1;
    check($sformatf("%s valid", name), rsp_valid, 1'b1);
    check($sformatf("%s result", name), result, exp);
    if (exp_lat >= 0) check($sformatf("%s latency", name), d, exp_lat);
    if (exp_lat > 0) check($sformatf("%s ready_low_busy", name), busy_bad, 1'b0);
    hold_bad = 1'b0;
    for (int i = 0; i < nhold; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!rsp_valid || result !== exp || req_ready) hold_bad = 1'b1;
    end
    if (nhold > 0) check($sformatf("%s held", name), hold_bad, 1'b0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check($sformatf("%s consumed", name), {rsp_valid, req_ready}, 2'b01);
  endtask

  // Clock a number of cycles and report whether any response appeared.
  task automatic watch_quiet(input string name, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check($sformatf("%s no_response", name), seen, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    logic [4:0] rops [10];
    logic [31:0] rl, rr;
    logic [4:0]  rop;

    resetb = 1'b0; clk_en = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    opcode = '0; left = '0; right = '0;
    req_valid64 = 1'b0; clk_en64 = 1'b1; flush64 = 1'b0; rsp_ready64 = 1'b0;
    opcode64 = '0; left64 = '0; right64 = '0;

    add("add_ovf",  RV_ALUOP_ADD,    32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0);
    add("sub",      RV_ALUOP_SUB,    32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0);
    add("sll",      RV_ALUOP_SLL,    32'h0000_0001, 32'h0000_0023, 32'h0000_0008, 0);
    add("slt",      RV_ALUOP_SLT,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0);
    add("sltu",     RV_ALUOP_SLTU,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0);
    add("xor",      RV_ALUOP_XOR,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0);
    add("srl",      RV_ALUOP_SRL,    32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 0);
    add("sra31",    RV_ALUOP_SRA,    32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    add("or",       RV_ALUOP_OR,     32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0, 0);
    add("and",      RV_ALUOP_AND,    32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 0);
    add("mov",      RV_ALUOP_MOV,    32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678, 0);
    add("badop",    5'd31,           32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    add("mul",      RV_ALUOP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
    add("mul_neg",  RV_ALUOP_MUL,    32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFF1, 33);
    add("mulh",     RV_ALUOP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    add("mulhsu",   RV_ALUOP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    add("mulhu",    RV_ALUOP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    add("div_ovf",  RV_ALUOP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    add("rem_ovf",  RV_ALUOP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    add("divu_z",   RV_ALUOP_DIVU,   32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 0);
    add("remu_z",   RV_ALUOP_REMU,   32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 0);
    add("div_z",    RV_ALUOP_DIV,    32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0);
    add("rem_m7",   RV_ALUOP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
    add("div_7m2",  RV_ALUOP_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    add("rem_7m2",  RV_ALUOP_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33);
    add("divu",     RV_ALUOP_DIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 33);
    add("remu",     RV_ALUOP_REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33);

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_state", {rsp_valid, req_ready, result}, {1'b0, 1'b1, 32'h0});
    resetb = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      do_op(vecs[i].name, vecs[i].op, vecs[i].l, vecs[i].r, vecs[i].exp, vecs[i].lat, 1, 1'b0);
    end

    // DIV -7/2 held unconsumed for five cycles.
    do_op("div_m7_hold5", RV_ALUOP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, 5, 1'b0);

    // Back-to-back single-cycle ops with the consumer always ready.
    rsp_ready = 1'b1; req_valid = 1'b1;
    opcode = RV_ALUOP_ADD; left = 32'd1; right = 32'd2;
    @(posedge clk); @(negedge clk);
    check("b2b_0", {rsp_valid, result}, {1'b1, 32'd3});
    check("b2b_ready", req_ready, 1'b1);
    opcode = RV_ALUOP_XOR; left = 32'd5; right = 32'd3;
    @(posedge clk); @(negedge clk);
    check("b2b_1", {rsp_valid, result}, {1'b1, 32'd6});
    opcode = RV_ALUOP_SUB; left = 32'd10; right = 32'd3;
    @(posedge clk); @(negedge clk);
    check("b2b_2", {rsp_valid, result}, {1'b1, 32'd7});
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("b2b_drain", rsp_valid, 1'b0);
    rsp_ready = 1'b0;

    // Flush on the 10th ITER edge of a DIVU.
    opcode = RV_ALUOP_DIVU; left = 32'd1000; right = 32'd7; req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    check("flush_idle", {rsp_valid, req_ready}, 2'b01);
    watch_quiet("flush", 40);
    do_op("after_flush_add", RV_ALUOP_ADD, 32'd2, 32'd3, 32'd5, 0, 1, 1'b0);

    // Reset asserted mid-ITER.
    opcode = RV_ALUOP_DIVU; left = 32'd1000; right = 32'd7; req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    resetb = 1'b0;
    #1;
    check("midreset_outputs", {rsp_valid, req_ready, result}, {1'b0, 1'b1, 32'h0});
    @(negedge clk);
    resetb = 1'b1;
    watch_quiet("midreset", 40);
    do_op("after_reset_add", RV_ALUOP_ADD, 32'h10, 32'h20, 32'h30, 0, 1, 1'b0);

    // Stall during ITER extends latency by the number of disabled edges.
    opcode = RV_ALUOP_MULHU; left = 32'hFFFF_FFFF; right = 32'hFFFF_FFFF; req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    d = 0;
    while (!rsp_valid && d < 300) begin
      if (d == 5) clk_en = 1'b0;
      if (d == 8) clk_en = 1'b1;
      @(posedge clk);
      d++;
      @(negedge clk);
    end
    clk_en = 1'b1;
    check("stall_result", {rsp_valid, result}, {1'b1, 32'hFFFF_FFFE});
    check("stall_latency", d, 36);
    clk_en = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("stall_no_consume", {rsp_valid, result}, {1'b1, 32'hFFFF_FFFE});
    clk_en = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    check("stall_consume", rsp_valid, 1'b0);

    // Random mix with random stalls and consumer gaps.
    rops = '{RV_ALUOP_ADD, RV_ALUOP_XOR, RV_ALUOP_SLTU, RV_ALUOP_MUL, RV_ALUOP_MULHU,
             RV_ALUOP_MULH, RV_ALUOP_DIVU, RV_ALUOP_REMU, RV_ALUOP_DIV, RV_ALUOP_REM};
    for (int i = 0; i < 12; i++) begin
      rop = rops[$urandom_range(0, 9)];
      rl  = $urandom;
      rr  = $urandom | 32'h1;
      do_op($sformatf("rand%0d", i), rop, rl, rr, ref_op(rop, rl, rr), -1,
            $urandom_range(0, 3), 1'b1);
    end

    // XLEN=64 MULHU of all-ones squared.
    opcode64 = RV_ALUOP_MULHU; left64 = '1; right64 = '1; req_valid64 = 1'b1;
    check("x64_ready", req_ready64, 1'b1);
    @(posedge clk); @(negedge clk);
    req_valid64 = 1'b0;
    d = 0;
    while (!rsp_valid64 && d < 300) begin
      @(posedge clk);
      d++;
      @(negedge clk);
    end
    check("x64_valid", rsp_valid64, 1'b1);
    check("x64_result", result64, 64'hFFFF_FFFF_FFFF_FFFE);
    check("x64_latency", d, 65);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/merlin_alu_md.md
# merlin_alu_md

Parametrised successor execution unit: single-cycle RV integer ALU ops plus iterative RV M-extension multiply/divide, XLEN-generic. Sits in the execute stage behind a valid/ready request port and a held valid/ready response port. This lets the pipeline stall on multi-cycle ops instead of assuming fixed one-cycle results.

## Interface
- XLEN, 32: datapath width; legal values 32 and 64.
- clk_i  in  1  clock.
- resetb_i  in  1  asynchronous active-low reset.
- clk_en_i  in  1  global stall. When low, all state is frozen and no handshake completes.
- flush_i  in  1  abort the in-flight op and drop any pending response.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  unit can accept a request.
- op_opcode_i  in  5  operation, `RV_ALUOP_*`.
- op_left_i / op_right_i  in  XLEN  operands (rs1 / rs2-or-imm).
- rsp_valid_o  out  1  result valid; held until consumed.
- rsp_ready_i  in  1  consumer takes the result.
- rsp_result_o  out  XLEN  registered result.

## Operation
- A request is accepted on an enabled edge where req_valid_i & req_ready_o & !flush_i.
- req_ready_o = (state==IDLE) & !(rsp_valid_o & !rsp_ready_i). It is combinational and high out of reset.
- States:
  - IDLE: waiting for a request.
  - ITER: XLEN iterations; counter runs XLEN-1 down to 0.
  - FIX: sign correction and selection of the upper or lower half.
- Single-cycle ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MOV (MOV returns op_right_i).
  - The result is registered at the accept edge and rsp_valid_o is set; state stays IDLE.
  - Shift amount is op_right_i[$clog2(XLEN)-1:0].
  - SRA fills with op_left_i[XLEN-1].
  - SLT/SLTU return 0 or 1, zero-extended.
- MUL, MULH, MULHSU, MULHU:
  - Operands are converted to magnitudes per signedness.
  - Radix-2 shift-add over a 2*XLEN accumulator in ITER.
  - FIX negates the product if signs differ, then selects the low half (MUL) or high half (others).
- DIV, DIVU, REM, REMU:
  - Radix-2 restoring division on magnitudes in ITER.
  - FIX: the quotient takes the sign of (sign_l ^ sign_r); the remainder takes the sign of the dividend.
- Fast-path special cases complete like single-cycle ops, with no ITER:
  - divisor==0: quotient all-ones, remainder = op_left_i.
  - Signed overflow (op_left_i == most-negative, op_right_i == all-ones, DIV/REM): quotient = op_left_i, remainder 0.
- Response handshake: rsp_valid_o and rsp_result_o stay stable while rsp_ready_i is low. rsp_valid_o clears on the enabled edge where rsp_ready_i is high, unless a new single-cycle result is loaded on that same edge.
- flush_i (enabled edge):
  - state -> IDLE, rsp_valid_o -> 0, counter cleared.
  - Takes precedence over a same-cycle accept and a same-cycle response consume.
- Unrecognised opcode: treated as single-cycle and returns 0.

## Timing
- Reset (async assert): state IDLE, rsp_valid_o 0, rsp_result_o 0, counter 0, internal registers 0.
- Single-cycle op or fast-path divide: accepted at edge k, rsp_valid_o high after edge k.
- MUL/DIV family: accepted at edge k. ITER occupies edges k+1..k+XLEN, FIX is edge k+XLEN+1, so rsp_valid_o is high after edge k+XLEN+1. Latency is XLEN+1 edges (33 for XLEN=32).
- Back-to-back single-cycle ops with rsp_ready_i held high give one result per cycle.
- A new request is not accepted until the previous response is consumed.
- With clk_en_i low, an ITER cycle does not count; latency extends by the number of disabled edges.
- Reset asserted mid-ITER returns immediately to reset values. No response is emitted.

## Structure
- The shared define file (`riscv_defs.v`) holds:
  - the existing `RV_ALUOP_*` codes, widened to 5 bits;
  - new codes RV_ALUOP_MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU;
  - RV_ALUOP_RANGE updated to [4:0].
- State encoding is local localparams.
- One natural sub-module, merlin_muldiv_iter: the ITER datapath with start/done, operand and sign registers, accumulator and counter. The top level holds the single-cycle ALU, special-case detection, FSM control and the response register.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 -> 0x80000000, rsp_valid_o one edge after accept. SRA 0x80000000 by 31 (op_right_i = 0xFFFFFFFF) -> 0xFFFFFFFF.
- MULH 0x80000000 * 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF. Both at exactly 33 edges; req_ready_o low throughout.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, at 1-edge latency. DIVU 0x1234 / 0 -> 0xFFFFFFFF; REMU -> 0x1234.
- DIV -7 / 2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF. Hold rsp_ready_i low 5 cycles: result stable, req_ready_o low; then consume.
- flush_i at the 10th ITER cycle of a DIVU: no response, req_ready_o high next cycle. A follow-on ADD returns correctly. Repeat with resetb_i pulsed mid-ITER: all outputs 0.
- XLEN=64: MULHU 0xFFFF_FFFF_FFFF_FFFF squared -> 0xFFFF_FFFF_FFFF_FFFE at 65 edges. Random ops vs. reference model with random clk_en_i / rsp_ready_i gaps.
